// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Holds funct3 op codes, FSM states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide, valid/ready on both sides.
// Build option MULDIV_FAST_ZERO_EN adds a 1-cycle path for trivial operands.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      Op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Negative,
  output logic            OverFlow,
  output logic            DivByZero
);

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nx;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi, lo, dvs;
  logic [CNT_W-1:0] cnt;

  logic            is_div, is_rem;
  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            dz, ovf, fz, fast;
  logic            accept;
  logic [XLEN-1:0] fast_res;

  assign is_div = Op[2];
  assign is_rem = Op[1];

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (Op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_sgn & A[XLEN-1];
  assign b_neg = b_sgn & B[XLEN-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign dz  = is_div & (B == '0);
  assign ovf = a_sgn & is_div
             & (A == MIN_NEG) & (&B);

`ifdef MULDIV_FAST_ZERO_EN
  assign fz = is_div ? (a_mag < b_mag)
                     : (A == '0 || B == '0);
`else
  assign fz = 1'b0;
`endif

  assign fast   = dz | ovf | fz;
  assign accept = in_ready & in_valid;

  // dz and ovf never coincide: ovf needs B all-ones
  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      dz:  fast_res = is_rem ? A : '1;
      ovf: fast_res = is_rem ? '0 : A;
      default:
        fast_res = (is_div & is_rem) ? A : '0;
    endcase
  end

  logic [XLEN:0]     sum;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   calc_res;

  assign sum  = {1'b0, hi}
              + (lo[0] ? {1'b0, dvs} : '0);
  assign ge   = {hi, lo[XLEN-1]} >= {1'b0, dvs};
  assign diff = {hi[XLEN-2:0], lo[XLEN-1]} - dvs;
  assign prod = neg_q ? -{hi, lo} : {hi, lo};

  always_comb begin
    calc_res = prod[2*XLEN-1:XLEN];
    unique case (1'b1)
      op_q == OP_MUL:
        calc_res = prod[XLEN-1:0];
      op_q[2] & ~op_q[1]:
        calc_res = neg_q ? -lo : lo;
      op_q[2] & op_q[1]:
        calc_res = neg_q ? -hi : hi;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = fast ? S_DONE : S_CALC;
      end
      S_CALC:
        if (cnt == CNT_W'(1)) state_nx = S_FIX;
      S_FIX:
        state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // hi:lo is the product for multiply, remainder:quotient for divide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dvs   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op_q  <= Op;
      neg_q <= (is_div & is_rem) ? a_neg
                                 : a_neg ^ b_neg;
      hi    <= '0;
      lo    <= is_div ? a_mag : b_mag;
      dvs   <= is_div ? b_mag : a_mag;
      cnt   <= CNT_W'(XLEN);
    end else if (state == S_CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (op_q[2]) begin
        hi <= ge ? diff
                 : {hi[XLEN-2:0], lo[XLEN-1]};
        lo <= {lo[XLEN-2:0], ge};
      end else begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Result    <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      OverFlow  <= 1'b0;
      DivByZero <= 1'b0;
    end else if (accept && fast) begin
      Result    <= fast_res;
      Zero      <= fast_res == '0;
      Negative  <= fast_res[XLEN-1];
      OverFlow  <= ovf;
      DivByZero <= dz;
    end else if (state == S_FIX) begin
      Result    <= calc_res;
      Zero      <= calc_res == '0;
      Negative  <= calc_res[XLEN-1];
      OverFlow  <= 1'b0;
      DivByZero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and random checks of alu_muldiv
// against a plain-arithmetic RV32M model.
module tb_alu_muldiv;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  Op = '0;
  logic        in_ready, out_valid;
  logic [31:0] Result;
  logic        Zero, Negative, OverFlow, DivByZero;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .Op(Op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result(Result),
    .Zero(Zero),
    .Negative(Negative),
    .OverFlow(OverFlow),
    .DivByZero(DivByZero)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        ovf,
    output logic        dbz,
    output logic        fast
  );
    logic signed [63:0] sa, sb, ua, ub, p, q;
    logic               sgn;
    logic [63:0]        ma, mb;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = 1'b0;
    dbz = 1'b0;
    r   = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV, OP_REM: begin
        if (b == 0) begin
          dbz = 1'b1;
          r = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 &&
                     b == 32'hFFFF_FFFF) begin
          ovf = 1'b1;
          r = (op == OP_DIV) ? a : 32'h0;
        end else begin
          q = (op == OP_DIV) ? sa / sb : sa % sb;
          r = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          dbz = 1'b1;
          r = (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        end else begin
          r = (op == OP_DIVU) ? a / b : a % b;
        end
      end
    endcase
    fast = ovf | dbz;
`ifdef MULDIV_FAST_ZERO_EN
    sgn = (op == OP_DIV) || (op == OP_REM);
    ma  = (sgn && a[31]) ? 64'(-sa) : 64'(ua);
    mb  = (sgn && b[31]) ? 64'(-sb) : 64'(ub);
    if (!op[2] && (a == 0 || b == 0)) fast = 1'b1;
    if (op[2] && ma < mb) fast = 1'b1;
`else
    sgn = 1'b0;
    ma  = '0;
    mb  = '0;
`endif
  endfunction

  // hold: cycles of out_ready=0 while a competing request is offered
  task automatic do_op(input logic [2:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int          hold);
    logic [31:0] er;
    logic        eo, ed, ef;
    int          w, lat;
    model(op, a, b, er, eo, ed, ef);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    Op = op; A = a; B = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), ef ? 64'(0) : 64'(XLEN + 1));
    chk("result", 64'(Result), 64'(er));
    chk("zero", 64'(Zero), 64'(er == 0));
    chk("negative", 64'(Negative), 64'(er[31]));
    chk("overflow", 64'(OverFlow), 64'(eo));
    chk("divbyzero", 64'(DivByZero), 64'(ed));
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        Op = OP_DIVU; A = 32'd5; B = 32'd0;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_ready", 64'(in_ready), 64'(0));
      chk("hold_result", 64'(Result), 64'(er));
      chk("hold_flags",
          64'({Zero, Negative, OverFlow, DivByZero}),
          64'({er == 0, er[31], eo, ed}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'(0));
    chk("ready_back", 64'(in_ready), 64'(1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      5: return -32'($urandom_range(1, 40));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    chk("rst_flags",
        64'({Zero, Negative, OverFlow, DivByZero}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 0);
    do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 0);
    do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         0);
    do_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         0);
    do_op(OP_DIVU,   32'hFFFF_FFF9, 32'd2,         0);
    do_op(OP_DIVU,   32'd5,         32'd0,         0);
    do_op(OP_REM,    32'd5,         32'd0,         0);
    do_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(OP_MUL,    32'd1234,      32'd5678,      5);

    // abort a multiply mid-calculation
    Op = OP_MUL; A = 32'd9; B = 32'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_result", 64'(Result), 64'(0));
    chk("abort_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(OP_MUL, 32'd3, 32'd4, 0);

    for (int n = 0; n < 200; n++)
      do_op(3'($urandom_range(0, 7)), pick(), pick(),
            int'($urandom_range(0, 2)));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide execution unit implementing the RV32M operations.
- Parametrised successor to the combinational ALU: width-generic, multi-cycle, valid/ready handshaked on both sides.
- Sits beside the ALU in the execute stage. The core stalls on in_ready/out_valid.
- Reports the same flag style as the ALU (Zero, Negative, OverFlow) plus a divide-by-zero flag.

Parameters:
- XLEN, 32, operand and result width; must be >= 4.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- A  in  XLEN  rs1 operand.
- B  in  XLEN  rs2 operand.
- Op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  Result and flags valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  XLEN  operation result.
- Zero  out  1  Result == 0.
- Negative  out  1  Result[XLEN-1].
- OverFlow  out  1  signed-division overflow (DIV/REM of most-negative by -1).
- DivByZero  out  1  DIV/DIVU/REM/REMU with B == 0.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; in_ready=1.
  - out_valid=0; Result=0; Zero, Negative, OverFlow, DivByZero = 0.
  - Reset mid-operation discards the operation; no result is emitted.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch Op, compute operand magnitudes and result sign, clear accumulator, counter=XLEN.
  - Special cases go to DONE directly (1-cycle fast path); all else goes to CALC.
- CALC:
  - One bit per cycle; counter decrements; leaves to FIX when counter reaches 1.
  - Multiply: shift-add on the unsigned 2*XLEN product.
  - Divide: restoring division; the quotient bit is set when the trial subtraction is non-negative.
- FIX:
  - Apply two's-complement sign correction.
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN].
  - DIV*: quotient. REM*: remainder.
  - Register Result and flags; go to DONE.
- DONE:
  - out_valid=1; Result and flags held stable.
  - On out_ready go to IDLE, out_valid=0 next cycle. in_ready rises in that same next cycle (one bubble; no overlap).
- Latency, accept edge to out_valid: XLEN+1 cycles normal (XLEN in CALC + 1 in FIX); 1 cycle on the fast path.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Division truncates toward zero; remainder takes the dividend's sign.
- Special cases (fast path):
  - B==0: DIV/DIVU give all-ones; REM/REMU give A; DivByZero=1.
  - Signed overflow (A = 1<<(XLEN-1), B = all-ones, DIV/REM): DIV gives A, REM gives 0; OverFlow=1.
- Flags:
  - OverFlow and DivByZero are 0 for all multiply ops.
  - Zero and Negative are always derived from the final Result.
- in_valid while busy is ignored; the requester holds the request until in_ready.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: additional fast-path cases, with out_valid 1 cycle after accept:
  - multiply with A==0 or B==0 gives Result 0;
  - unsigned-magnitude |A|<|B| for division gives quotient 0 and remainder A (sign per rules).
- Undefined: these cases take the full XLEN+1 cycles. Results are identical either way.

Decomposition:
- Shared package muldiv_pkg:
  - Op encodings (OP_MUL … OP_REMU) as localparams.
  - State encoding (S_IDLE, S_CALC, S_FIX, S_DONE).
  - Default XLEN.
- No sub-module required. Single module alu_muldiv containing the FSM, datapath and sign logic.

Test Plan (XLEN=32):
- MUL A=7, B=-3 (0xFFFFFFFD) -> Result 0xFFFFFFEB, N=1, Z=0; out_valid exactly 33 cycles after accept.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 (0xFFFFFFF9) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIVU 5/0 -> 0xFFFFFFFF, DivByZero=1, out_valid 1 cycle after accept. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, OverFlow=1. REM same -> 0, Z=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> Result and flags stable, in_ready=0. A new in_valid during DONE is not accepted. After the out_ready handshake, in_ready=1 next cycle.
- Reset mid-CALC (cycle 10): rst low -> immediately out_valid=0, Result=0, in_ready=1. After release, a new MUL 3×4 -> 12 with normal latency.
